// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
package lsu_pkg;

    localparam int          MEM_WORDS  = 1024;
    localparam logic [31:0] ADDR_LIMIT = 32'h0000_1000;  // 1024 words * 4 bytes

    // RV32I width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // Returns 1 when the access must be rejected without touching memory.
    function automatic logic lsu_req_err(input logic        we,
                                         input logic [2:0]  funct3,
                                         input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        if (addr >= ADDR_LIMIT) bad = 1'b1;
        case (funct3)
            F3_B, F3_BU: bad = bad;
            F3_H, F3_HU: if (addr[0]) bad = 1'b1;
            F3_W:        if (addr[1:0] != 2'b00) bad = 1'b1;
            default:     bad = 1'b1;
        endcase
        // Stores have no unsigned variants
        if (we && funct3[2]) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load lane extract/extension and store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [4:0]  w_shift;
    logic [15:0] w_lane;
    logic [31:0] w_mask;

    assign w_shift = {i_byte_off, 3'b000};
    assign w_lane  = 16'(i_rword >> w_shift);

    // Load: pull the addressed lane down to bit 0 and extend it
    always_comb begin
        o_load_data = i_rword;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            F3_H:    o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            F3_BU:   o_load_data = {24'b0, w_lane[7:0]};
            F3_HU:   o_load_data = {16'b0, w_lane[15:0]};
            default: o_load_data = i_rword;
        endcase
    end

    // Store: replace only the addressed byte/halfword lanes of the read word
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (i_funct3[1:0])
            2'b00:   w_mask = 32'h0000_00FF << w_shift;
            2'b01:   w_mask = 32'h0000_FFFF << w_shift;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
        o_store_word = (i_rword & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a 1024-word data memory.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [11:0] r_addr;       // upper bits are known zero once an access is accepted
    logic [31:0] r_wdata;
    logic [31:0] r_wword;      // word that WRITE puts on the memory bus
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_accept = req_valid && (r_state == IDLE);

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_byte_off   (r_addr[1:0]),
        .i_rword      (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // Control FSM with captured request and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 12'h000;
            r_wdata  <= 32'h0;
            r_wword  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr[11:0];
                        r_wdata  <= req_wdata;
                        if (lsu_req_err(req_we, req_funct3, req_addr)) begin
                            r_rdata <= 32'h0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else if (!req_we) begin
                            r_state <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            r_wword <= req_wdata;
                            r_state <= WRITE;
                        end else begin
                            r_state <= RMW_READ;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                    r_state <= RESP;
                end
                RMW_READ: begin
                    r_wword <= w_store_word;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_rdata <= 32'h0;
                    r_err   <= 1'b0;
                    r_state <= RESP;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are pure state decode of registers, so reset clears them immediately
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_we     = (r_state == WRITE) && r_we;
    assign mem_wdata  = mem_we ? r_wword : 32'h0;
    assign mem_addr   = (r_state == IDLE) ? 32'h0 : {22'b0, r_addr[11:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset-abort sequence, random vs byte-level model.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge
    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    // Reference memory kept as a flat byte array
    logic [7:0] rb [0:4095];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int k = 0; k < 4; k++) rb[4*idx+k] = 8'(w >> (8*k));
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
    endfunction

    // Architectural model: what the access should return and how long it takes
    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rd,
                             output logic er, output int lat);
        int size;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        er = (addr > 32'h0FFF) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
             (we && f3[2]) || ((addr % size) != 0);
        rd = 32'h0;
        if (er) begin
            lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(rb[addr+k]) << (8*k));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
            lat = 2;
        end else begin
            for (int k = 0; k < size; k++) rb[addr+k] = 8'(wdata >> (8*k));
            lat = (size == 4) ? 2 : 3;
        end
    endtask

    // Issue one access; report response, latency and any memory writes seen
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nwe, output logic [31:0] waddr, output logic [31:0] wword);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Garbage on req_* after accept must be ignored
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nwe = 0; rd = 32'h0; er = 1'b0; waddr = 32'h0; wword = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            if (mem_we) begin nwe++; waddr = mem_addr; wword = mem_wdata; end
            if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; break; end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            chk({tag, ".pulse1"}, 32'(resp_valid), 32'd0);
            chk({tag, ".hold"}, {resp_rdata[30:0], resp_err}, {rd[30:0], er});
        end
    endtask

    task automatic run_one(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_er, input int exp_lat,
                           input logic [31:0] exp_word);
        logic [31:0] rd, waddr, wword;
        logic er;
        int lat, nwe;
        access(we, f3, addr, wdata, tag, rd, er, lat, nwe, waddr, wword);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, 32'(er), 32'(exp_er));
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".nwe"}, 32'(nwe), (we && !exp_er) ? 32'd1 : 32'd0);
        if (we && !exp_er) begin
            chk({tag, ".waddr"}, waddr, {22'b0, addr[11:2]});
            chk({tag, ".wword"}, wword, exp_word);
            chk({tag, ".memword"}, mem[addr[11:2]], exp_word);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] m_rd;
        logic        m_er;
        int          m_lat;
        logic        seen;

        tbl[0]  = '{1'b0, 3'b000, 32'h17,   32'h0,        32'hFFFF_FF88, 1'b0, 2, 32'h0};
        tbl[1]  = '{1'b0, 3'b101, 32'h14,   32'h0,        32'h0000_AABB, 1'b0, 2, 32'h0};
        tbl[2]  = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF_8899, 1'b0, 2, 32'h0};
        tbl[3]  = '{1'b1, 3'b000, 32'h15,   32'h1234_56CC, 32'h0,        1'b0, 3, 32'h8899_CCBB};
        tbl[4]  = '{1'b0, 3'b100, 32'h15,   32'h0,        32'h0000_00CC, 1'b0, 2, 32'h0};
        tbl[5]  = '{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,         1'b1, 1, 32'h0};
        tbl[6]  = '{1'b1, 3'b010, 32'h1000, 32'h5555_5555, 32'h0,        1'b1, 1, 32'h0};
        tbl[7]  = '{1'b1, 3'b001, 32'h16,   32'hFFFF_7777, 32'h0,        1'b0, 3, 32'h7777_CCBB};
        tbl[8]  = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h7777_CCBB, 1'b0, 2, 32'h0};
        tbl[9]  = '{1'b1, 3'b100, 32'h14,   32'h0000_0011, 32'h0,        1'b1, 1, 32'h0};
        tbl[10] = '{1'b0, 3'b001, 32'h15,   32'h0,        32'h0,         1'b1, 1, 32'h0};
        tbl[11] = '{1'b0, 3'b011, 32'h14,   32'h0,        32'h0,         1'b1, 1, 32'h0};
        tbl[12] = '{1'b1, 3'b010, 32'h14,   32'hCAFE_F00D, 32'h0,        1'b0, 2, 32'hCAFE_F00D};
        tbl[13] = '{1'b0, 3'b000, 32'h14,   32'h0,        32'h0000_000D, 1'b0, 2, 32'h0};

        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        set_word(5, 32'h8899_AABB);
        set_word(8, 32'h0102_0304);

        // Reset state
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err",   32'(resp_err),   32'd0);
        chk("rst.resp_rdata", resp_rdata,      32'd0);
        chk("rst.mem_we",     32'(mem_we),     32'd0);
        chk("rst.mem_wdata",  mem_wdata,       32'd0);
        chk("rst.mem_addr",   mem_addr,        32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.ready", 32'(req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            ref_model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_er, m_lat);
            run_one($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                    tbl[i].exp_rd, tbl[i].exp_er, tbl[i].exp_lat, tbl[i].exp_word);
        end

        // Reset during WRITE of SW 0x20 aborts the store and the response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort.in_write", 32'(mem_we), 32'd1);
        chk("abort.addr", mem_addr, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.we_drop", 32'(mem_we), 32'd0);
        chk("abort.addr0", mem_addr, 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        if (resp_valid) seen = 1'b1;
        chk("abort.noresp", 32'(seen), 32'd0);
        chk("abort.ready", 32'(req_ready), 32'd1);
        chk("abort.word8", mem[8], 32'h0102_0304);
        run_one("abort.lw", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0102_0304, 1'b0, 2, 32'h0);

        // Random accesses against the byte-level model
        for (int i = 0; i < 300; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wdata;
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            wdata = $urandom;
            ref_model(we, f3, addr, wdata, m_rd, m_er, m_lat);
            run_one($sformatf("rnd%0d", i), we, f3, addr, wdata, m_rd, m_er, m_lat,
                    (we && !m_er) ? ref_word(int'(addr[11:2])) : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all flops rising-edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req_valid, input, 1, core presents an access.
REQ-004 SHALL have port req_ready, output, 1, unit accepts the access this cycle.
REQ-005 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-006 SHALL have port req_funct3, input, 3, RV32I width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err, output, 1, access rejected; valid with resp_valid.
REQ-012 SHALL have port mem_addr, output, 32, word index to data memory.
REQ-013 SHALL have port mem_wdata, output, 32, word to write.
REQ-014 SHALL have port mem_we, output, 1, memory write enable.
REQ-015 SHALL have port mem_rdata, input, 32, combinational read word from memory (valid only while mem_we=0).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept occurs when req_valid&&req_ready at a rising edge.
REQ-018 SHALL capture we, funct3, addr, wdata at accept and hold them until RESP exits.
REQ-019 SHALL drive mem_addr={22'b0, addr[11:2]} (1024-word space) from the captured address in every non-IDLE state; 0 in IDLE.
REQ-020 SHALL flag error (no memory access, go IDLE->RESP) for: addr[31:12]!=0; halfword with addr[0]=1; word with addr[1:0]!=0; funct3 011/110/111; store with funct3[2]=1.
REQ-021 Load: IDLE->LOAD->RESP; in LOAD, mem_we=0, and mem_rdata lane selected by addr[1:0] is registered into resp_rdata, sign-extended for LB/LH, zero-extended for LBU/LHU/LW.
REQ-022 SW: IDLE->WRITE->RESP; WRITE drives mem_we=1, mem_wdata=wdata.
REQ-023 SB/SH: IDLE->RMW_READ->WRITE->RESP; RMW_READ registers mem_rdata (mem_we=0); WRITE writes that word with only the addressed byte/halfword lanes replaced by wdata[7:0]/[15:0].
REQ-024 SHALL assert mem_we only in WRITE, exactly one cycle per store.
REQ-025 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; no back-to-back accept from RESP.
REQ-026 Latency accept->resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-027 req_* inputs changing outside the accept cycle SHALL have no effect.
REQ-028 resp_rdata and resp_err SHALL hold their values until the next resp_valid.

Reset
REQ-029 On rst_n=0 state SHALL go to IDLE asynchronously; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wdata=0, mem_addr=0.
REQ-030 Reset asserted mid-operation SHALL abort the access with no write and no response; mem_we falls without waiting for clk.
REQ-031 After rst_n deasserts, req_ready=1 at the first clk edge.

Structure
REQ-032 Package lsu_pkg SHALL hold funct3 constants, FSM state enum, MEM_WORDS=1024 and ADDR_LIMIT.
REQ-033 Sub-module lsu_align SHALL be combinational: lane extract + extension for loads, lane merge for stores.
REQ-034 All outputs SHALL be driven from registers or state decode only; no combinational path from req_* to mem_*.

Verification
REQ-035 Memory word 5 = 0x8899AABB; LB addr 0x17 -> resp_rdata=0xFFFFFF88, resp_err=0, 2 cycles after accept.
REQ-036 Same word; LHU addr 0x14 -> resp_rdata=0x0000AABB; LH addr 0x16 -> 0xFFFF8899.
REQ-037 SB addr 0x15 wdata 0x123456CC -> one mem_we pulse at index 5 writing 0x8899CCBB; resp_valid 3 cycles after accept.
REQ-038 LW addr 0x102 -> resp_err=1, resp_rdata=0, mem_we never asserted; SW addr 0x1000 -> resp_err=1.
REQ-039 SW addr 0x20 wdata 0xDEADBEEF, rst_n pulsed low during WRITE -> mem_we drops immediately, no resp_valid, word 8 unchanged; next LW addr 0x20 reads original value.
